// File: rtl/micspi_sampler_pkg.sv
// Shared types and constants for the MEMs PMod MIC serial sampler.
package micspi_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int SAMPLE_BITS  = 12;
    localparam int LEAD_BITS    = 4;
    localparam int SHIFT_HALVES = 2 * FRAME_BITS;

    // One conversion spans this many SCK half-periods, from tick to IDLE.
    localparam int CONV_HALVES  = 34;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TAIL
    } state_t;

endpackage

// File: rtl/micspi_sampler_if.sv
// Bundles the sampler's control, ADC pins and sample-FIFO write port.
interface micspi_sampler_if
    import micspi_pkg::*;
#(
    parameter int RW = 20
);

    logic                   i_en;
    logic [RW-1:0]          i_rate;
    logic                   i_miso;
    logic                   o_csn;
    logic                   o_sck;
    logic                   o_stb;
    logic [SAMPLE_BITS-1:0] o_data;
    logic                   o_miss;
    logic                   o_err;

    modport master (
        input  i_en, i_rate, i_miso,
        output o_csn, o_sck, o_stb, o_data, o_miss, o_err
    );

    modport slave (
        output i_en, i_rate, i_miso,
        input  o_csn, o_sck, o_stb, o_data, o_miss, o_err
    );

endinterface

// File: rtl/micspi_sampler_tick.sv
// Sample-rate divider: reloads from rate, pulses tick on reaching zero while enabled.
module micspi_tick #(
    parameter int RW = 20
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          en,
    input  logic [RW-1:0] rate,
    output logic          tick
);

    logic [RW-1:0] count;

    // Reloading on every disabled cycle makes a rate change land at the next reload.
    always_ff @(posedge i_clk) begin
        if (i_rst || !en || count == '0) begin
            count <= rate;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = en && (count == '0);

endmodule

// File: rtl/micspi_sampler.sv
// ADCS7476 serial front end: paces conversions, drives CS_n/SCK, emits 12-bit samples.
// Optional lead-zero frame check is built when MICSPI_ZCHECK_EN is defined.
module micspi_sampler
    import micspi_pkg::*;
#(
    parameter int CKDIV = 4,
    parameter int RW    = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    micspi_sampler_if.master bus
);

    localparam int CW = $clog2(CKDIV);
    localparam int HW = $clog2(SHIFT_HALVES);

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          cnt;
    logic [HW-1:0]          half;
    logic [1:0]             miso_sync;
    logic [FRAME_BITS-1:0]  shreg;
    logic                   tick;
    logic                   cnt_last;
    logic                   sck_low;
    logic                   last_half;
    logic                   capture;
    logic                   frame_done;
    logic                   lead_ok;
    logic                   stb_q;
    logic [SAMPLE_BITS-1:0] data_q;

    micspi_tick #(.RW(RW)) u_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .en    (bus.i_en),
        .rate  (bus.i_rate),
        .tick  (tick)
    );

    assign cnt_last   = (cnt == CW'(CKDIV - 1));
    assign sck_low    = (state == SHIFT) && !half[0];
    assign last_half  = (half == HW'(SHIFT_HALVES - 1));
    assign capture    = sck_low && cnt_last;
    // One cycle before the SHIFT->TAIL transition, so the registered strobe lands on it.
    assign frame_done = (state == SHIFT) && last_half && (cnt == CW'(CKDIV - 2));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick arriving on the final TAIL cycle starts the next frame back to back.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = LEAD;
            LEAD:    if (cnt_last) state_next = SHIFT;
            SHIFT:   if (cnt_last && last_half) state_next = TAIL;
            TAIL:    if (cnt_last) state_next = tick ? LEAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_csn  = (state == IDLE) || (state == TAIL);
        bus.o_sck  = !sck_low;
        bus.o_miss = tick && !((state == IDLE) || ((state == TAIL) && cnt_last));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt  <= '0;
            half <= '0;
        end else begin
            cnt <= ((state == IDLE) || cnt_last) ? '0 : cnt + 1'b1;
            if (state != SHIFT) begin
                half <= '0;
            end else if (cnt_last) begin
                half <= half + 1'b1;
            end
        end
    end

    // Capture on the SCK rising edge sees the pin as it was two clocks earlier.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            miso_sync <= '0;
            shreg     <= '0;
        end else begin
            miso_sync <= {miso_sync[0], bus.i_miso};
            if (capture) begin
                shreg <= {shreg[FRAME_BITS-2:0], miso_sync[1]};
            end
        end
    end

`ifdef MICSPI_ZCHECK_EN
    logic err_q;

    assign lead_ok = (shreg[FRAME_BITS-1 -: LEAD_BITS] == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (frame_done && !lead_ok) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    logic unused_lead;

    assign lead_ok     = 1'b1;
    assign unused_lead = ^shreg[FRAME_BITS-1 -: LEAD_BITS];
    assign bus.o_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stb_q  <= 1'b0;
            data_q <= '0;
        end else begin
            stb_q <= frame_done && lead_ok;
            if (frame_done && lead_ok) begin
                data_q <= shreg[SAMPLE_BITS-1:0];
            end
        end
    end

    assign bus.o_stb  = stb_q;
    assign bus.o_data = data_q;

endmodule

// File: doc/micspi_sampler.md
# micspi_sampler

Serial front end for the MEMs PMod MIC (ADCS7476-class 12-bit ADC). It paces conversions from a programmable sample-rate divider and drives the chip's CS_n/SCK. It shifts in each 16-bit serial frame and emits one 12-bit sample strobe per conversion. It sits directly upstream of the sample FIFO: `o_stb`/`o_data` connect to the FIFO's write strobe and write data.

## Interface
- `CKDIV`, default 4: SCK half-period in `i_clk` cycles. Must be ≥3 (synchronizer margin).
- `RW`, default 20: width of the rate divider.
- `i_clk`  in  1  system clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_en`  in  1  enable sampling; level
- `i_rate`  in  RW  sample period minus one, in `i_clk` cycles
- `i_miso`  in  1  ADC serial data (asynchronous pin)
- `o_csn`  out  1  ADC chip select, active low
- `o_sck`  out  1  ADC serial clock, idles high
- `o_stb`  out  1  one-cycle strobe: new sample valid
- `o_data`  out  12  last sample, held between strobes
- `o_miss`  out  1  one-cycle pulse: rate tick arrived while converting
- `o_err`  out  1  sticky frame error (see Configuration)

## Operation
- **Rate tick:** counter loads `i_rate` and decrements to 0, then pulses `tick` and reloads. When `i_en`=0 it holds at `i_rate` and produces no tick.
- **MISO synchronizer:** `i_miso` passes through a 2-flop synchronizer. All captures use the synchronized value.
- **FSM states:** IDLE, LEAD, SHIFT, TAIL.
  - IDLE→LEAD on `tick`. `o_csn` goes 0, `o_sck` stays 1, for CKDIV cycles.
  - SHIFT runs 16 bits. Each bit: `o_sck`=0 for CKDIV cycles, then `o_sck`=1 for CKDIV cycles.
  - The synchronized MISO is shifted in (MSB first) on the cycle `o_sck` is driven 0→1.
  - After the 16th high phase: SHIFT→TAIL. `o_csn`=1 for CKDIV cycles, then TAIL→IDLE.
- **Output:** on the SHIFT→TAIL transition cycle, `o_data` takes frame bits [11:0] and `o_stb` is asserted for exactly that one cycle.
- **Busy tick:** a `tick` outside IDLE is dropped and `o_miss` pulses. No queuing.
- **`i_en` falling mid-conversion:** the current frame completes and its sample is delivered. Further ticks are suppressed.
- **`i_rate` change:** takes effect at the next reload.

## Timing
- **Reset values:** `o_csn`=1, `o_sck`=1, `o_stb`=0, `o_data`=0, `o_miss`=0, `o_err`=0. FSM=IDLE, rate counter=`i_rate`.
- **Reset mid-frame:** the next cycle is IDLE with CS high. No partial sample is emitted.
- **Conversion length:** 34·CKDIV cycles (`tick` to return to IDLE). A miss-free rate requires `i_rate`+1 ≥ 34·CKDIV.
- **Tick-to-strobe latency:** 33·CKDIV cycles.
- **Capture window:** data is launched by the ADC on SCK fall or CS fall. The captured value reflects the pin 2 cycles before the rising edge.

## Configuration
- `MICSPI_ZCHECK_EN` defined: the 4 leading frame bits [15:12] must be 0.
  - On a nonzero lead, `o_stb` is suppressed for that frame and `o_err` sets.
  - `o_err` stays set until `i_rst`.
- Undefined: every frame strobes regardless of the lead bits, and `o_err` is tied 0.

## Structure
- Package `micspi_pkg`:
  - FSM state enum
  - `FRAME_BITS`=16, `SAMPLE_BITS`=12, `LEAD_BITS`=4
  - conversion-length constant 34
- Sub-module `micspi_tick`: rate divider with enable, producing single-cycle `tick`.

## Test plan
- **Basic frame:** CKDIV=4, `i_rate`=199, ADC model returns 0x0ABC. Required: `o_stb` every 200 cycles, `o_data`=0xABC, CS low for 132 cycles, 16 SCK rises, `o_miss` never.
- **Too-fast rate:** `i_rate`=99 (below 136). Required: `o_miss` pulse on alternate ticks, one sample per 200 cycles, no frame corruption.
- **Disable mid-frame:** `i_en` drops 40 cycles after `tick`. Required: that frame's strobe still appears at tick+132, then no further CS activity.
- **Reset mid-frame:** `i_rst` at tick+60. Required: next cycle `o_csn`=1, `o_sck`=1, no `o_stb`. Sampling resumes cleanly after release.
- **Lead check with `MICSPI_ZCHECK_EN`:** model returns 0x1ABC. Required: no `o_stb`, `o_err`=1 and sticky. A next frame of 0x0123 strobes with `o_data`=0x123.
- **Lead check without `MICSPI_ZCHECK_EN`:** model returns 0x1ABC. Required: `o_stb` with `o_data`=0xABC, `o_err`=0.
